// File: rtl/rf_ctrl_pkg.sv
// Package: rf_ctrl_pkg
// Shared register-file types and constants for the write-port arbiter.
//   RF_PW        register pointer width (file holds 2**RF_PW entries)
//   RF_W         register data width
//   RF_ZERO_ADDR address of the hardwired-zero register r0
// Optional feature macro used by users of this package: RF_BYPASS_EN.
package rf_ctrl_pkg;

    localparam int unsigned RF_PW = 3;
    localparam int unsigned RF_W  = 8;

    typedef logic [RF_PW:0]  rf_addr_t;
    typedef logic [RF_W-1:0] rf_data_t;

    typedef struct packed {
        rf_addr_t addr;
        rf_data_t dat;
    } rf_wr_t;

    localparam rf_addr_t RF_ZERO_ADDR = '0;

endpackage

// File: rtl/rr_pick.sv
// Module: rr_pick
// Combinational round-robin picker: searches req starting at index ptr,
// wrapping modulo N, and returns the first requester found.
// Ports:
//   req  in  N   request vector
//   ptr  in  IW  search start index (0..N-1)
//   gnt  out N   one-hot grant, 0 when req is 0
//   idx  out IW  index of the granted requester (0 when none)
//   any  out 1   a grant was issued
module rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int unsigned pos;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = 0;
        for (int unsigned k = 0; k < N; k++) begin
            // Rotated position, wrapped without a modulo operator.
            pos = 32'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Module: rf_wr_arbiter
// Round-robin arbiter sharing the single register-file write port between
// NREQ writeback sources. One registered write per cycle; writes to r0 or to
// an out-of-range address are accepted but dropped and counted.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high
//   hold      in   freeze: no grants, wr_en loads 0, pointer frozen
//   req       in   NREQ          per-source write request
//   req_addr  in   NREQ*(PW+1)   source i at [i*(PW+1)+:PW+1]
//   req_dat   in   NREQ*8        source i at [i*8+:8]
//   gnt       out  NREQ          one-hot combinational grant
//   wr_en     out  registered register-file write enable
//   wr_addr   out  PW+1 registered write address
//   dat_out   out  8 registered write data
//   drop_cnt  out  8 saturating count of dropped writes
// Optional (macro RF_BYPASS_EN): rd_addrA/rd_addrB in, bypA/B_hit and
// bypA/B_dat out, forwarding the pending write to same-cycle readers.
module rf_wr_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned PW   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   hold,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*(PW+1)-1:0] req_addr,
    input  logic [NREQ*RF_W-1:0]   req_dat,
    output logic [NREQ-1:0]        gnt,
    output logic                   wr_en,
    output logic [PW:0]            wr_addr,
    output rf_data_t               dat_out,
`ifdef RF_BYPASS_EN
    input  logic [PW:0]            rd_addrA,
    input  logic [PW:0]            rd_addrB,
    output logic                   bypA_hit,
    output rf_data_t               bypA_dat,
    output logic                   bypB_hit,
    output rf_data_t               bypB_dat,
`endif
    output logic [7:0]             drop_cnt
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] req_eff;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   ptr_d;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [PW:0]     sel_addr;
    rf_data_t        sel_dat;
    logic            sel_drop;

    // Reset and hold both suppress grants so nothing is accepted and lost.
    assign req_eff = (reset || hold) ? '0 : req;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req (req_eff),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        sel_addr = '0;
        sel_dat  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*(PW+1) +: PW+1];
                sel_dat  = req_dat[i*RF_W +: RF_W];
            end
        end
    end

    // r0 is hardwired to zero; the top address bit flags an out-of-range target.
    assign sel_drop = (sel_addr[PW-1:0] == '0) || sel_addr[PW];

    always_comb begin
        ptr_d = ptr_q;
        if (pick_any) begin
            ptr_d = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            dat_out  <= '0;
            drop_cnt <= '0;
        end else begin
            ptr_q <= ptr_d;
            wr_en <= pick_any && !sel_drop;
            // Address/data hold their last value on idle cycles.
            if (pick_any) begin
                wr_addr <= sel_addr;
                dat_out <= sel_dat;
            end
            if (pick_any && sel_drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

`ifdef RF_BYPASS_EN
    assign bypA_hit = wr_en && (wr_addr == rd_addrA) && (rd_addrA != '0);
    assign bypB_hit = wr_en && (wr_addr == rd_addrB) && (rd_addrB != '0);
    assign bypA_dat = bypA_hit ? dat_out : '0;
    assign bypB_dat = bypB_hit ? dat_out : '0;
`endif

endmodule
